pc_gen_unit: RTL
================

# pc_gen_unit

Parametrised next-generation PC generator at the head of the fetch pipeline. Produces one fetch-block address per cycle toward the fetch stage over a valid/ready handshake. Selects the next PC from, in priority order: trap redirect, branch-resolution recovery, halt, front-end prediction, then the sequential block. Adds a return-address stack (RAS) for call/return prediction, multi-instruction fetch blocks, a boot/run/halt state machine and a flush indication to downstream stages.

## Interface
- XLEN, 32, address width
- BOOT_PC, 32'h0000_1000, reset/boot fetch address
- FETCH_BYTES, 8, bytes per fetch block (power of two, ≥4); SLOTS = FETCH_BYTES/4
- RAS_DEPTH, 8, return-address stack entries (≥2)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- trap_valid_i  in  1  trap/exception redirect request
- trap_target_i  in  XLEN  trap handler address
- res_valid_i  in  1  branch resolution valid
- res_mispredict_i  in  1  resolved branch was mispredicted
- res_taken_i  in  1  resolved branch direction
- res_target_i  in  XLEN  resolved taken target
- res_pc_i  in  XLEN  address of the resolved branch
- halt_i  in  1  stop issuing fetch addresses
- pred_taken_i  in  1  predictor: taken control transfer in current block
- pred_target_i  in  XLEN  predicted target
- pred_slot_i  in  max(1,log2(SLOTS))  slot of predicted instruction within block
- pred_call_i  in  1  predicted instruction is a call (push RAS)
- pred_ret_i  in  1  predicted instruction is a return (pop RAS)
- fetch_ready_i  in  1  fetch stage accepts pc_o
- pc_o  out  XLEN  current fetch address
- pc_valid_o  out  1  pc_o valid
- flush_o  out  1  pc_o is first address after a redirect; kill in-flight fetches
- ras_count_o  out  log2(RAS_DEPTH)+1  valid RAS entries

## Operation
- base = pc_o with low log2(FETCH_BYTES) bits cleared; seq = base + FETCH_BYTES (modulo 2^XLEN, wraps).
- Accept = pc_valid_o && fetch_ready_i. Prediction inputs are ignored unless Accept.
- Next-PC priority, evaluated every cycle:
  - trap_valid_i: next = trap_target_i; RAS count cleared to 0; flush.
  - else res_valid_i && res_mispredict_i: next = res_taken_i ? res_target_i : res_pc_i + 4; RAS untouched; flush.
  - else state HALT or halt_i: pc_o held.
  - else Accept && pred_ret_i && ras_count_o > 0: next = RAS top; pop.
  - else Accept && pred_taken_i: next = pred_target_i.
  - else Accept: next = seq.
  - else: pc_o held (stable while valid && !ready).
- All next-PC values have bits [1:0] forced to 0.
- Redirects apply regardless of fetch_ready_i or halt; the current unaccepted pc_o is dropped.
- RAS push (Accept && pred_call_i, no redirect this cycle): value base + 4*(pred_slot_i+1). Circular buffer; when full, push overwrites the oldest entry and count stays RAS_DEPTH.
- pred_ret_i with empty RAS: no pop, falls through to pred_taken_i/pred_target_i.
- Call and return in the same accepted cycle: pop then push (top entry replaced, count unchanged when nonempty).
- FSM states:
  - BOOT: pc_valid_o=0; goes to RUN after one cycle, or HALT if halt_i.
  - RUN: pc_valid_o=1; goes to HALT when halt_i and no redirect.
  - HALT: pc_valid_o=0, pc_o held; returns to RUN when halt_i=0. A trap in HALT loads trap_target_i and goes to RUN even if halt_i=1.
  - A mispredict in HALT updates pc_o but stays in HALT.

## Timing
- Reset values: pc_o=BOOT_PC, pc_valid_o=0, flush_o=0, ras_count_o=0, state BOOT.
- Reset asserted mid-operation clears everything to reset values immediately (asynchronous). The first valid BOOT_PC appears in the second cycle after deassertion.
- Latency: one cycle from any input decision to the new pc_o. flush_o is registered and high for exactly the one cycle the redirected pc_o first appears, including when it appears with pc_valid_o=0 (HALT).
- Back-to-back redirects: each cycle's highest-priority redirect wins; flush_o stays high on consecutive cycles.
- pc_o and pc_valid_o must not change while pc_valid_o && !fetch_ready_i, except on a redirect, halt or reset.

## Test plan
- Reset, then fetch_ready_i=1, no predictions (FETCH_BYTES=8) -> cycle 1 pc_valid_o=0 at 0x1000; then pc_o = 0x1000, 0x1008, 0x1010, …; starting at 0xFFFF_FFF8 the next block wraps to 0x0.
- fetch_ready_i=0 for 3 cycles at pc_o=0x1008 -> pc_o holds 0x1008 and valid stays 1; prediction inputs are ignored during the stall.
- Accepted call at slot 1 in block 0x2000, target 0x3000 -> next pc_o=0x3000 and ras_count_o=1. A later accepted return -> next pc_o=0x2008 and ras_count_o=0. A return on the empty RAS with pred_target_i=0x4000 and pred_taken_i=1 -> next pc_o=0x4000.
- RAS_DEPTH+1 calls pushing A0..A8 -> count saturates at 8. Eight returns yield A8..A1; the next return finds the RAS empty.
- Same-cycle trap(0x8000), mispredict and taken prediction -> next pc_o=0x8000, flush_o=1 for one cycle, ras_count_o=0. Mispredict alone, not taken, res_pc_i=0x2004 -> next pc_o=0x2008 and flush_o=1.
- halt_i=1 in RUN -> pc_valid_o=0 next cycle with pc_o held. Trap while halted -> pc_o=trap target, flush_o=1, state RUN. Reset mid-stream -> immediate pc_o=0x1000, valid=0.

Source files
------------

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: next fetch-block PC generator at the head of the fetch pipeline.
//   Picks the next PC from, in priority order: trap redirect, branch-resolution
//   recovery, halt, RAS-predicted return, predicted taken target, sequential block.
//   Runs a boot/run/halt state machine and keeps a circular return-address stack.
// Ports:
//   clk_i, rst_i (async, active-high)
//   trap_*_i   : trap redirect request and handler address
//   res_*_i    : branch resolution (mispredict recovery)
//   halt_i     : stop issuing fetch addresses
//   pred_*_i   : front-end prediction for the current block (used only on accept)
//   fetch_ready_i / pc_o / pc_valid_o : valid/ready handshake toward fetch
//   flush_o    : pc_o is the first address after a redirect
//   ras_count_o: number of valid RAS entries
module pc_gen_unit #(
  parameter int XLEN                 = 32,
  parameter logic [XLEN-1:0] BOOT_PC = 32'h0000_1000,
  parameter int FETCH_BYTES          = 8,
  parameter int RAS_DEPTH            = 8,
  localparam int SLOTS  = FETCH_BYTES / 4,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int CNT_W  = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_target_i,
  input  logic              res_valid_i,
  input  logic              res_mispredict_i,
  input  logic              res_taken_i,
  input  logic [XLEN-1:0]   res_target_i,
  input  logic [XLEN-1:0]   res_pc_i,
  input  logic              halt_i,
  input  logic              pred_taken_i,
  input  logic [XLEN-1:0]   pred_target_i,
  input  logic [SLOT_W-1:0] pred_slot_i,
  input  logic              pred_call_i,
  input  logic              pred_ret_i,
  input  logic              fetch_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              pc_valid_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  ras_count_o
);

  localparam int OFF_W = $clog2(FETCH_BYTES);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [XLEN-1:0]   ras_q [RAS_DEPTH];

  logic              accept;
  logic              mispredict;
  logic              redirect;
  logic              hold;
  logic              pop_en;
  logic              push_en;
  logic              ras_wr_en;
  logic [PTR_W-1:0]  ras_wr_idx;
  logic [XLEN-1:0]   base;
  logic [XLEN-1:0]   seq;
  logic [XLEN-1:0]   push_val;
  logic [XLEN-1:0]   next_raw;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;

  assign pc_o        = pc_q;
  assign pc_valid_o  = (state_q == ST_RUN);
  assign flush_o     = flush_q;
  assign ras_count_o = cnt_q;

  assign accept     = pc_valid_o & fetch_ready_i;
  assign mispredict = res_valid_i & res_mispredict_i;
  assign redirect   = trap_valid_i | mispredict;
  assign hold       = (state_q == ST_HALT) | halt_i;

  assign base     = {pc_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign seq      = base + XLEN'(FETCH_BYTES);
  // Return address is the instruction after the call slot.
  assign push_val = base + XLEN'({pred_slot_i, 2'b00}) + XLEN'(4);

  // Depth need not be a power of two, so wrap the pointer explicitly.
  assign top_inc = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

  // A pop is only taken when the return actually steers the PC; a push only
  // needs an accepted call without a redirect.
  assign pop_en  = ~redirect & ~hold & accept & pred_ret_i & (cnt_q != '0);
  assign push_en = ~redirect & accept & pred_call_i;

  // Next-PC selection.
  always_comb begin
    next_raw = pc_q;
    flush_d  = redirect;
    if (trap_valid_i) begin
      next_raw = trap_target_i;
    end else if (mispredict) begin
      next_raw = res_taken_i ? res_target_i : res_pc_i + XLEN'(4);
    end else if (hold) begin
      next_raw = pc_q;
    end else if (pop_en) begin
      next_raw = ras_q[top_q];
    end else if (accept && pred_taken_i) begin
      next_raw = pred_target_i;
    end else if (accept) begin
      next_raw = seq;
    end
    pc_d = next_raw & ~XLEN'(3);
  end

  // RAS pointer/count update. Pop-then-push collapses into overwriting the top.
  always_comb begin
    cnt_d      = cnt_q;
    top_d      = top_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = top_q;
    if (trap_valid_i) begin
      cnt_d = '0;
    end else if (pop_en && push_en) begin
      ras_wr_en = 1'b1;
    end else if (pop_en) begin
      top_d = top_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push_en) begin
      top_d      = top_inc;
      ras_wr_idx = top_inc;
      ras_wr_en  = 1'b1;
      // When full the push lands on the oldest entry; count saturates.
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State machine next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: begin
        if (trap_valid_i)  state_d = ST_RUN;
        else if (halt_i)   state_d = ST_HALT;
        else               state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!redirect && halt_i) state_d = ST_HALT;
      end
      ST_HALT: begin
        // Trap always resumes; mispredict only moves the PC while halted.
        if (trap_valid_i)    state_d = ST_RUN;
        else if (mispredict) state_d = ST_HALT;
        else if (!halt_i)    state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
      pc_q    <= BOOT_PC;
      flush_q <= 1'b0;
      cnt_q   <= '0;
      top_q   <= PTR_W'(RAS_DEPTH - 1);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
    end
  end

  // Entries are only meaningful below the count, so storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (ras_wr_en) begin
      ras_q[ras_wr_idx] <= push_val;
    end
  end

endmodule
